// File: rtl/z80_bus_fabric_if.sv
// rtl/z80_bus_fabric_if.sv - Z80 bus-side signal bundle between CPU/decoder and the fabric
interface z80_bus_fabric_if #(
  parameter int NCH    = 4,
  parameter int WAIT_W = 4
);
  logic                    i_rd_n;
  logic                    i_wr_n;
  logic [NCH-1:0]          i_cs_n;
  logic [8*NCH-1:0]        i_ch_data;
  logic [WAIT_W*NCH-1:0]   i_wait_cfg;
  logic [NCH-1:0]          i_rdy;
  logic                    o_wait_n;
  logic [7:0]              o_data;
  logic                    o_data_en;

  // CPU, decoder and slaves drive the bus inputs
  modport master (
    output i_rd_n, i_wr_n, i_cs_n, i_ch_data, i_wait_cfg, i_rdy,
    input  o_wait_n, o_data, o_data_en
  );

  // the fabric consumes the bus and generates WAIT and read data
  modport slave (
    input  i_rd_n, i_wr_n, i_cs_n, i_ch_data, i_wait_cfg, i_rdy,
    output o_wait_n, o_data, o_data_en
  );
endinterface

// File: rtl/z80_bus_fabric.sv
// rtl/z80_bus_fabric.sv - Z80 wait-state generator and read-data mux for NCH slave channels
module z80_bus_fabric #(
  parameter int NCH    = 4,
  parameter int WAIT_W = 4,
  parameter int TMO    = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  z80_bus_fabric_if.slave  bus,
  input  logic             i_err_clr,
  output logic             o_tmo_err,
  output logic             o_multi_err,
  output logic [2:0]       o_err_ch
);

  localparam int TMO_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY, S_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_tmo_err, w_tmo_err_nxt;
  logic                r_multi_err, w_multi_err_nxt;
  logic [2:0]          r_err_ch, w_err_ch_nxt;

  logic [NCH-1:0]      w_cs_act;
  logic                w_multi;
  logic                w_act;
  logic [2:0]          w_sel;
  logic [WAIT_W-1:0]   w_cfg_sel;
  logic                w_rdy_sel;
  logic [7:0]          w_dat_sel;

  assign w_cs_act = ~bus.i_cs_n;
  assign w_multi  = |(w_cs_act & (w_cs_act - NCH'(1)));
  // reset gates ACT so WAIT releases and data-in is dropped while held in reset
  assign w_act    = i_reset_n & (|w_cs_act) & (~bus.i_rd_n | ~bus.i_wr_n);

  // priority-select the lowest-index active channel and pick up its cfg/ready/data
  always_comb begin
    w_sel     = 3'd0;
    w_cfg_sel = bus.i_wait_cfg[WAIT_W-1:0];
    w_rdy_sel = bus.i_rdy[0];
    w_dat_sel = bus.i_ch_data[7:0];
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_cs_act[k]) begin
        w_sel     = 3'(k);
        w_cfg_sel = bus.i_wait_cfg[WAIT_W*k +: WAIT_W];
        w_rdy_sel = bus.i_rdy[k];
        w_dat_sel = bus.i_ch_data[8*k +: 8];
      end
    end
  end

  // next-state, counters, data capture and error flags
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tmo_nxt       = r_tmo;
    w_data_nxt      = r_data;
    w_tmo_err_nxt   = r_tmo_err;
    w_multi_err_nxt = r_multi_err;
    w_err_ch_nxt    = r_err_ch;

    // clear first so an error detected on the same edge overrides it
    if (i_err_clr) begin
      w_tmo_err_nxt   = 1'b0;
      w_multi_err_nxt = 1'b0;
      w_err_ch_nxt    = 3'd0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_act) begin
          w_tmo_nxt = '0;
          // the IDLE clock is already the first wait clock, so WAIT covers cfg-1 more
          w_cnt_nxt = (w_cfg_sel != '0) ? (w_cfg_sel - WAIT_W'(1)) : '0;
          w_state_nxt = (w_cfg_sel > WAIT_W'(1)) ? S_WAIT : S_RDY;
          if (w_multi) begin
            w_multi_err_nxt = 1'b1;
            w_err_ch_nxt    = w_sel;
          end
        end
      end
      S_WAIT: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
          if (r_cnt == WAIT_W'(1)) begin
            w_state_nxt = S_RDY;
            w_tmo_nxt   = '0;
          end
        end
      end
      S_RDY: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
        end else if (w_rdy_sel) begin
          w_state_nxt = S_HOLD;
          w_data_nxt  = w_dat_sel;
        end else if (r_tmo >= TMO_W'(TMO - 1)) begin
          w_state_nxt   = S_HOLD;
          w_data_nxt    = 8'hFF;
          w_tmo_err_nxt = 1'b1;
          w_err_ch_nxt  = w_sel;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_HOLD: begin
        if (!w_act) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state and flag registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_data      <= 8'h00;
      r_tmo_err   <= 1'b0;
      r_multi_err <= 1'b0;
      r_err_ch    <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_data      <= w_data_nxt;
      r_tmo_err   <= w_tmo_err_nxt;
      r_multi_err <= w_multi_err_nxt;
      r_err_ch    <= w_err_ch_nxt;
    end
  end

  // WAIT is held while counting and while the selected slave is not ready
  always_comb begin
    bus.o_wait_n = ~(w_act & (
                     ((r_state == S_IDLE) & ((w_cfg_sel != '0) | ~w_rdy_sel)) |
                     (r_state == S_WAIT) |
                     ((r_state == S_RDY) & ~w_rdy_sel)));
  end

  // read data: live mux until the captured value takes over in HOLD
  always_comb begin
    bus.o_data_en = w_act & ~bus.i_rd_n;
    bus.o_data    = 8'h00;
    if (bus.o_data_en) bus.o_data = (r_state == S_HOLD) ? r_data : w_dat_sel;
  end

  assign o_tmo_err   = r_tmo_err;
  assign o_multi_err = r_multi_err;
  assign o_err_ch    = r_err_ch;

endmodule

// File: tb/tb_z80_bus_fabric.sv
// tb/tb_z80_bus_fabric.sv - directed vector bench for z80_bus_fabric
module tb_z80_bus_fabric;
  localparam int NCH    = 4;
  localparam int WAIT_W = 4;
  localparam int TMO    = 8;
  // ch3=15, ch2=3, ch1=1, ch0=0 wait states
  localparam logic [15:0] CFG  = 16'hF310;
  // ch3=3C, ch2=A5, ch1=5A, ch0=96
  localparam logic [31:0] DATA = 32'h3CA55A96;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic       tmo_err, multi_err;
  logic [2:0] err_ch;

  z80_bus_fabric_if #(.NCH(NCH), .WAIT_W(WAIT_W)) bus ();

  z80_bus_fabric #(.NCH(NCH), .WAIT_W(WAIT_W), .TMO(TMO)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .bus         (bus),
    .i_err_clr   (err_clr),
    .o_tmo_err   (tmo_err),
    .o_multi_err (multi_err),
    .o_err_ch    (err_ch)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       clr;
    logic [3:0] cs_n;
    logic       rd;
    logic [3:0] rdy;
    int         exp_wait;
    logic [7:0] exp_first;
    logic [7:0] exp_hold;
    logic       exp_tmo;
    logic       exp_multi;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t v [9];

  task automatic bus_idle();
    bus.i_cs_n    = 4'hF;
    bus.i_rd_n    = 1'b1;
    bus.i_wr_n    = 1'b1;
    bus.i_rdy     = 4'hF;
    bus.i_ch_data = DATA;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic run_access(input logic [3:0] cs_n, input logic rd, input logic [3:0] rdy,
                            output int waits, output logic [7:0] d_first,
                            output logic [7:0] d_hold, output logic den_hold,
                            output logic [7:0] d_after, output logic den_after);
    @(negedge clk);
    bus.i_cs_n    = cs_n;
    bus.i_rd_n    = ~rd;
    bus.i_wr_n    = rd;
    bus.i_rdy     = rdy;
    bus.i_ch_data = DATA;
    #1;
    d_first = bus.o_data;
    waits   = 0;
    while (bus.o_wait_n == 1'b0 && waits < 100) begin
      waits++;
      @(negedge clk); #1;
    end
    @(negedge clk);
    @(negedge clk);
    bus.i_ch_data = 32'h0;
    #1;
    d_hold   = bus.o_data;
    den_hold = bus.o_data_en;
    @(negedge clk);
    bus_idle();
    #1;
    d_after   = bus.o_data;
    den_after = bus.o_data_en;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         w;
    logic [7:0] df, dh, da;
    logic       eh, ea;

    v[0] = '{1'b0, 4'b1011, 1'b1, 4'hF,    3, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'd0};
    v[1] = '{1'b0, 4'b1110, 1'b1, 4'hF,    0, 8'h96, 8'h96, 1'b0, 1'b0, 3'd0};
    v[2] = '{1'b0, 4'b1101, 1'b1, 4'b1101, 9, 8'h5A, 8'hFF, 1'b1, 1'b0, 3'd1};
    v[3] = '{1'b1, 4'b1100, 1'b0, 4'hF,    0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0};
    v[4] = '{1'b1, 4'b0111, 1'b1, 4'hF,   15, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0};
    v[5] = '{1'b0, 4'b1101, 1'b1, 4'hF,    1, 8'h5A, 8'h5A, 1'b0, 1'b0, 3'd0};
    v[6] = '{1'b0, 4'b1001, 1'b1, 4'hF,    1, 8'h5A, 8'h5A, 1'b0, 1'b1, 3'd1};
    v[7] = '{1'b1, 4'b1110, 1'b1, 4'b1110, 9, 8'h96, 8'hFF, 1'b1, 1'b0, 3'd0};
    v[8] = '{1'b0, 4'b1011, 1'b0, 4'hF,    3, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0};

    bus.i_wait_cfg = CFG;
    bus_idle();
    bus.i_cs_n = 4'h0;
    bus.i_rd_n = 1'b0;
    #12;
    check("reset_wait_n",  32'(bus.o_wait_n),  32'd1);
    check("reset_data_en", 32'(bus.o_data_en), 32'd0);
    check("reset_data",    32'(bus.o_data),    32'h00);
    check("reset_flags",   32'({tmo_err, multi_err, err_ch}), 32'd0);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (v[i].clr) pulse_clr();
      run_access(v[i].cs_n, v[i].rd, v[i].rdy, w, df, dh, eh, da, ea);
      check($sformatf("v%0d_waits", i),     32'(w),         32'(v[i].exp_wait));
      check($sformatf("v%0d_data_first", i), 32'(df),       32'(v[i].exp_first));
      check($sformatf("v%0d_data_hold", i), 32'(dh),        32'(v[i].exp_hold));
      check($sformatf("v%0d_den_hold", i),  32'(eh),        32'(v[i].rd));
      check($sformatf("v%0d_data_after", i), 32'(da),       32'h00);
      check($sformatf("v%0d_den_after", i), 32'(ea),        32'd0);
      check($sformatf("v%0d_tmo_err", i),   32'(tmo_err),   32'(v[i].exp_tmo));
      check($sformatf("v%0d_multi_err", i), 32'(multi_err), 32'(v[i].exp_multi));
      check($sformatf("v%0d_err_ch", i),    32'(err_ch),    32'(v[i].exp_ch));
    end

    // clear and a new multi-select error on the same edge: new error wins, tmo clears
    @(negedge clk);
    bus.i_cs_n = 4'b1001;
    bus.i_rd_n = 1'b0;
    err_clr    = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("clr_vs_err_multi", 32'(multi_err), 32'd1);
    check("clr_vs_err_tmo",   32'(tmo_err),   32'd0);
    check("clr_vs_err_ch",    32'(err_ch),    32'd1);
    @(negedge clk);
    @(negedge clk);
    bus_idle();
    @(negedge clk);

    // reset while counting wait states on a cfg=15 channel
    @(negedge clk);
    bus.i_cs_n = 4'b0111;
    bus.i_rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_wait_pre", 32'(bus.o_wait_n), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_wait_n",  32'(bus.o_wait_n),  32'd1);
    check("rst_data_en", 32'(bus.o_data_en), 32'd0);
    check("rst_flags",   32'({tmo_err, multi_err, err_ch}), 32'd0);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    run_access(4'b0111, 1'b1, 4'hF, w, df, dh, eh, da, ea);
    check("post_rst_waits", 32'(w),  32'd15);
    check("post_rst_data",  32'(dh), 32'h3C);
    check("post_rst_flags", 32'({tmo_err, multi_err}), 32'd0);

    // strobes drop mid-WAIT: no error, next access gets the full wait
    @(negedge clk);
    bus.i_cs_n = 4'b0111;
    bus.i_rd_n = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1;
    check("abort_wait_pre", 32'(bus.o_wait_n), 32'd0);
    bus_idle();
    #1;
    check("abort_wait_n", 32'(bus.o_wait_n), 32'd1);
    @(negedge clk);
    run_access(4'b0111, 1'b1, 4'hF, w, df, dh, eh, da, ea);
    check("abort_next_waits", 32'(w), 32'd15);
    check("abort_flags", 32'({tmo_err, multi_err, err_ch}), 32'd0);

    // multi-select write followed by an explicit clear
    run_access(4'b1001, 1'b0, 4'hF, w, df, dh, eh, da, ea);
    check("wr_multi_waits", 32'(w), 32'd1);
    check("wr_multi_flag",  32'({multi_err, err_ch}), 32'({1'b1, 3'd1}));
    pulse_clr();
    #1;
    check("clr_flags", 32'({tmo_err, multi_err, err_ch}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
